// File: rtl/multicycle_divider.sv
// Iterative restoring divider, signed or unsigned, resolving BITS_PER_CYCLE quotient bits per cycle.
// Divide-by-zero and signed overflow finish one cycle after start with fixed results.
module multicycle_divider #(
  parameter int unsigned DIV_WIDTH      = 8,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 sign,
  input  logic [DIV_WIDTH-1:0] in1,
  input  logic [DIV_WIDTH-1:0] in2,
  output logic [DIV_WIDTH-1:0] q,
  output logic [DIV_WIDTH-1:0] r,
  output logic                 ready,
  output logic                 busy,
  output logic                 dbz,
  output logic                 ovf
);

  localparam int unsigned W  = DIV_WIDTH;
  localparam int unsigned N  = DIV_WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CW = $clog2(N + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  logic [1:0]    state, state_nx;
  logic [W-1:0]  dvd;   // dividend shifting out, quotient shifting in
  logic [W-1:0]  dvs;   // divisor magnitude
  logic [W-1:0]  rem;   // partial remainder, always below dvs
  logic [W-1:0]  dvd_step, rem_step;
  logic [CW-1:0] cnt;
  logic          neg_q, neg_r, dbz_p, ovf_p;
  logic          zero_c, ovf_c;
  logic [W-1:0]  in1_abs_c, in2_abs_c;

  assign zero_c    = (in2 == '0);
  assign ovf_c     = sign && (in1 == MOST_NEG) && (in2 == '1);
  assign in1_abs_c = (sign && in1[W-1]) ? (~in1 + W'(1)) : in1;
  assign in2_abs_c = (sign && in2[W-1]) ? (~in2 + W'(1)) : in2;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; special cases skip straight to FIX
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (start) state_nx = (zero_c || ovf_c) ? FIX : CALC;
      CALC:       if (cnt == CW'(N - 1)) state_nx = FIX;
      FIX:        state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  // BITS_PER_CYCLE restoring steps chained combinationally
  always_comb begin : step
    logic [W:0] trial;
    logic [W:0] diff;
    trial    = '0;
    diff     = '0;
    dvd_step = dvd;
    rem_step = rem;
    for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
      trial    = {rem_step, dvd_step[W-1]};
      diff     = trial - {1'b0, dvs};
      dvd_step = {dvd_step[W-2:0], ~diff[W]};
      rem_step = diff[W] ? trial[W-1:0] : diff[W-1:0];
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd   <= '0;
      dvs   <= '0;
      rem   <= '0;
      cnt   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dbz_p <= 1'b0;
      ovf_p <= 1'b0;
      q     <= '0;
      r     <= '0;
      ready <= 1'b0;
      busy  <= 1'b0;
      dbz   <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            neg_q <= sign && (in1[W-1] ^ in2[W-1]);
            neg_r <= sign && in1[W-1];
            dbz_p <= zero_c;
            ovf_p <= ovf_c;
            dvd   <= (zero_c || ovf_c) ? in1 : in1_abs_c;
            dvs   <= in2_abs_c;
            rem   <= '0;
            cnt   <= '0;
            ready <= 1'b0;
            dbz   <= 1'b0;
            ovf   <= 1'b0;
            busy  <= 1'b1;
          end
        end
        CALC: begin
          dvd <= dvd_step;
          rem <= rem_step;
          cnt <= cnt + CW'(1);
        end
        FIX: begin
          if (dbz_p) begin
            q   <= '1;
            r   <= dvd;
            dbz <= 1'b1;
          end else if (ovf_p) begin
            q   <= dvd;
            r   <= '0;
            ovf <= 1'b1;
          end else begin
            q <= neg_q ? (~dvd + W'(1)) : dvd;
            r <= neg_r ? (~rem + W'(1)) : rem;
          end
          ready <= 1'b1;
          busy  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_divider.sv
// Directed bench for multicycle_divider: three instances (1, 2 and 4 bits per cycle) share stimulus
// and are checked against hand-computed quotients, remainders, flags and latencies.
module tb_multicycle_divider;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst, start, sign;
  logic [W-1:0] in1, in2;
  logic [W-1:0] q1, r1, q2, r2, q4, r4;
  logic         ready1, busy1, dbz1, ovf1;
  logic         ready2, busy2, dbz2, ovf2;
  logic         ready4, busy4, dbz4, ovf4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  multicycle_divider #(.DIV_WIDTH(W), .BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .sign(sign), .in1(in1), .in2(in2),
    .q(q1), .r(r1), .ready(ready1), .busy(busy1), .dbz(dbz1), .ovf(ovf1));

  multicycle_divider #(.DIV_WIDTH(W), .BITS_PER_CYCLE(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .sign(sign), .in1(in1), .in2(in2),
    .q(q2), .r(r2), .ready(ready2), .busy(busy2), .dbz(dbz2), .ovf(ovf2));

  multicycle_divider #(.DIV_WIDTH(W), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .sign(sign), .in1(in1), .in2(in2),
    .q(q4), .r(r4), .ready(ready4), .busy(busy4), .dbz(dbz4), .ovf(ovf4));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One operation on all three instances; pulse_at > 0 re-pulses start (in1=50) before that edge
  task automatic run_op(input string tag, input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input logic ed, input logic eo,
                        input int pulse_at);
    int lat1 = 0;
    int lat2 = 0;
    int lat4 = 0;
    bit special = ed || eo;
    @(negedge clk);
    sign = s; in1 = a; in2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, " busy@0"}, 32'(busy1), 32'd1);
    check({tag, " ready@0"}, 32'(ready1), 32'd0);
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (lat1 == 0 && ready1) lat1 = c;
      if (lat2 == 0 && ready2) lat2 = c;
      if (lat4 == 0 && ready4) lat4 = c;
      if (lat1 != 0 && lat2 != 0 && lat4 != 0) break;
      if (c + 1 == pulse_at) begin
        @(negedge clk);
        start = 1'b1; in1 = 8'd50;
      end
    end
    check({tag, " lat1"}, 32'(lat1), special ? 32'd1 : 32'd9);
    check({tag, " lat2"}, 32'(lat2), special ? 32'd1 : 32'd5);
    check({tag, " lat4"}, 32'(lat4), special ? 32'd1 : 32'd3);
    check({tag, " q1"}, 32'(q1), 32'(eq));
    check({tag, " r1"}, 32'(r1), 32'(er));
    check({tag, " q2"}, 32'(q2), 32'(eq));
    check({tag, " r2"}, 32'(r2), 32'(er));
    check({tag, " q4"}, 32'(q4), 32'(eq));
    check({tag, " r4"}, 32'(r4), 32'(er));
    check({tag, " dbz"}, {29'd0, dbz1, dbz2, dbz4}, ed ? 32'd7 : 32'd0);
    check({tag, " ovf"}, {29'd0, ovf1, ovf2, ovf4}, eo ? 32'd7 : 32'd0);
    check({tag, " busy_end"}, {29'd0, busy1, busy2, busy4}, 32'd0);
  endtask

  initial begin
    int hi;
    rst = 1'b1; start = 1'b0; sign = 1'b0; in1 = '0; in2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset q", 32'(q1), 32'd0);
    check("reset r", 32'(r1), 32'd0);
    check("reset flags", {28'd0, ready1, busy1, dbz1, ovf1}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("s 26/7",     1'b1, 8'd26,     8'd7,      8'd3,      8'd5,      1'b0, 1'b0, 0);
    run_op("s -26/7",    1'b1, 8'(-26),   8'd7,      8'(-3),    8'(-5),    1'b0, 1'b0, 0);
    run_op("s -26/-7",   1'b1, 8'(-26),   8'(-7),    8'd3,      8'(-5),    1'b0, 1'b0, 0);
    run_op("s -7/26",    1'b1, 8'(-7),    8'd26,     8'd0,      8'(-7),    1'b0, 1'b0, 0);
    run_op("u 200/7",    1'b0, 8'd200,    8'd7,      8'd28,     8'd4,      1'b0, 1'b0, 0);
    run_op("u 255/1",    1'b0, 8'd255,    8'd1,      8'd255,    8'd0,      1'b0, 1'b0, 0);
    run_op("u 255/16",   1'b0, 8'd255,    8'd16,     8'd15,     8'd15,     1'b0, 1'b0, 0);
    run_op("u 128/255",  1'b0, 8'd128,    8'd255,    8'd0,      8'd128,    1'b0, 1'b0, 0);
    run_op("s 26/0",     1'b1, 8'd26,     8'd0,      8'hFF,     8'd26,     1'b1, 1'b0, 0);
    run_op("s -128/-1",  1'b1, 8'h80,     8'hFF,     8'h80,     8'd0,      1'b0, 1'b1, 0);
    run_op("u 5/0",      1'b0, 8'd5,      8'd0,      8'hFF,     8'd5,      1'b1, 1'b0, 0);
    run_op("s 100/9",    1'b1, 8'd100,    8'd9,      8'd11,     8'd1,      1'b0, 1'b0, 0);
    run_op("s -128/2",   1'b1, 8'h80,     8'd2,      8'(-64),   8'd0,      1'b0, 1'b0, 0);
    run_op("s 127/-3",   1'b1, 8'd127,    8'(-3),    8'(-42),   8'd1,      1'b0, 1'b0, 0);
    run_op("s 100/-1",   1'b1, 8'd100,    8'hFF,     8'(-100),  8'd0,      1'b0, 1'b0, 0);
    run_op("ignored",    1'b1, 8'd26,     8'd7,      8'd3,      8'd5,      1'b0, 1'b0, 3);

    // start held high: back-to-back operations on the 1-bit instance
    @(negedge clk);
    sign = 1'b1; in1 = 8'd26; in2 = 8'd7; start = 1'b1;
    @(posedge clk);
    hi = 0;
    for (int c = 1; c <= 19; c++) begin
      @(posedge clk); #1;
      if (ready1) hi++;
      if (c == 9)  check("b2b ready@9", 32'(ready1), 32'd1);
      if (c == 9)  check("b2b q@9", 32'(q1), 32'd3);
      if (c == 10) check("b2b ready@10", 32'(ready1), 32'd0);
      if (c == 19) check("b2b ready@19", 32'(ready1), 32'd1);
    end
    check("b2b ready count", 32'(hi), 32'd2);
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(posedge clk);

    // asynchronous reset in the middle of CALC
    @(negedge clk);
    sign = 1'b1; in1 = 8'd26; in2 = 8'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midrst q", 32'(q1), 32'd0);
    check("midrst r", 32'(r1), 32'd0);
    check("midrst ready/busy", {30'd0, ready1, busy1}, 32'd0);
    check("midrst q4", 32'(q4), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("after rst",  1'b1, 8'(-26),   8'd7,      8'(-3),    8'(-5),    1'b0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
